// File: rtl/ram_stream_reader_pkg.sv
// Shared definitions for the grid RAM stream blocks: default RAM geometry
// and the reader FSM state encoding.
package ram_stream_reader_pkg;

  localparam int DEF_DATA_WIDTH    = 16;
  localparam int DEF_DEPTH         = 16;
  localparam int DEF_ADDRESS_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } reader_state_t;

endpackage

// File: rtl/ram_stream_reader_sync_fifo.sv
// Small register-based synchronous FIFO with occupancy count; depth need not
// be a power of two. Storage clears on reset so the head reads 0 when idle.
module sync_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int SKID_DEPTH = 4,
  localparam int PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1,
  localparam int CW = $clog2(SKID_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic [CW-1:0]         count,
  output logic                  empty,
  output logic                  full
);

  localparam logic [PW-1:0] LAST_PTR = PW'(SKID_DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(SKID_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic                  push_en, pop_en;

  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_CNT);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign push_en  = push & ~full;
  assign pop_en   = pop & ~empty;

  generate
    for (genvar gi = 0; gi < SKID_DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          mem_q[gi] <= '0;
        end else if (push_en && wr_ptr_q == PW'(gi)) begin
          mem_q[gi] <= push_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      case ({push_en, pop_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ram_stream_reader.sv
// Streaming read engine: sweeps a wrap-around RAM address range, absorbs the
// one-cycle registered read latency and emits words as a valid/ready stream.
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int DEPTH         = DEF_DEPTH,
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int SKID_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] base_addr,
  input  logic [ADDRESS_WIDTH:0]   length,
  output logic [ADDRESS_WIDTH-1:0] read_address,
  input  logic [DATA_WIDTH-1:0]    ram_data,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done
);

  localparam int CW = $clog2(SKID_DEPTH + 1);
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);
  localparam logic [CW:0]              SKID_LIM  = (CW + 1)'(SKID_DEPTH);

  reader_state_t state_q, state_d;

  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [ADDRESS_WIDTH:0]   length_q, issued_q, accepted_q;
  logic                     rd_valid_q;
  logic                     issue, accept_cmd, pop, issue_ok;
  logic [CW-1:0]            fifo_count;
  logic                     fifo_empty, fifo_full;
  logic [CW:0]              load;

  // Data already requested from the RAM counts against FIFO space, so a
  // stalled sink can never cause an overflow.
  assign load     = {1'b0, fifo_count} + {{CW{1'b0}}, rd_valid_q};
  assign issue_ok = (load < SKID_LIM) && !fifo_full;
  assign pop      = out_valid & out_ready;

  assign read_address = addr_q;
  assign out_valid    = ~fifo_empty;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    issue      = 1'b0;
    accept_cmd = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept_cmd = 1'b1;
          state_d    = (length == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (issue_ok) begin
          issue = 1'b1;
          if (issued_q + 1'b1 == length_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && (accepted_q + 1'b1 == length_q)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      length_q   <= '0;
      issued_q   <= '0;
      accepted_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= issue;
      if (accept_cmd) begin
        addr_q     <= base_addr;
        length_q   <= length;
        issued_q   <= '0;
        accepted_q <= '0;
      end else begin
        if (issue) begin
          addr_q   <= (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
          issued_q <= issued_q + 1'b1;
        end
        if (pop) accepted_q <= accepted_q + 1'b1;
      end
    end
  end

  sync_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .SKID_DEPTH(SKID_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (rd_valid_q),
    .push_data(ram_data),
    .pop      (pop),
    .pop_data (out_data),
    .count    (fifo_count),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader paired with a mem[i]=i registered-read RAM.
module tb_ram_stream_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  base_addr;
  logic [4:0]  length;
  logic [3:0]  read_address;
  logic [15:0] ram_data;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  int tests_run = 0;
  int tests_failed = 0;

  logic [15:0] mem [16];
  logic [15:0] got_q [$];
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data = '0;
  int          fifo_max = 0;

  always #5 clk = ~clk;

  ram_stream_reader #(
    .DATA_WIDTH(16), .DEPTH(16), .ADDRESS_WIDTH(4), .SKID_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .read_address(read_address), .ram_data(ram_data), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
  );

  initial for (int i = 0; i < 16; i++) mem[i] = 16'(i);
  always @(posedge clk) ram_data <= mem[read_address];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Words accepted downstream are captured mid-cycle, as are stall checks.
  always @(negedge clk) begin
    if (prev_stall && !rst) begin
      check("stall_valid", 32'(out_valid), 1);
      check("stall_data", 32'(out_data), 32'(prev_data));
    end
    prev_stall = out_valid && !out_ready && !rst;
    prev_data  = out_data;
    if (out_valid && out_ready) got_q.push_back(out_data);
    if (int'(dut.u_fifo.count) > fifo_max) fifo_max = int'(dut.u_fifo.count);
  end

  task automatic run_read(input int base, input int len, input int random_ready,
                          input int pulse, input string tag);
    int n;
    got_q.delete();
    base_addr = 4'(base);
    length    = 5'(len);
    start     = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!done && n < 300) begin
      out_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pulse != 0 && n == 3) begin
        start = 1'b1; base_addr = 4'd7; length = 5'd2;
      end else begin
        start = 1'b0;
      end
      tick();
      n++;
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 32'(done), 1);
    check({tag, "_count"}, 32'(got_q.size()), 32'(len));
    for (int i = 0; i < got_q.size() && i < len; i++)
      check($sformatf("%s_word%0d", tag, i), 32'(got_q[i]), 32'((base + i) % 16));
    tick();
    check({tag, "_done_pulse"}, 32'(done), 0);
    check({tag, "_idle"}, 32'(busy), 0);
    out_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b1;
    tick(); tick();
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_addr", 32'(read_address), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    rst = 1'b0;
    tick();

    // Cycle-exact timing of a 5-word read: first word after edge E2, done after E7.
    base_addr = 4'd3; length = 5'd5; start = 1'b1;
    tick();
    start = 1'b0;
    check("t_e0_busy", 32'(busy), 1);
    check("t_e0_valid", 32'(out_valid), 0);
    check("t_e0_addr", 32'(read_address), 3);
    tick();
    check("t_e1_valid", 32'(out_valid), 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("t_valid%0d", k), 32'(out_valid), 1);
      check($sformatf("t_data%0d", k), 32'(out_data), 32'(3 + k));
      check($sformatf("t_nodone%0d", k), 32'(done), 0);
    end
    tick();
    check("t_end_valid", 32'(out_valid), 0);
    check("t_end_done", 32'(done), 1);
    tick();
    check("t_after_done", 32'(done), 0);
    check("t_after_busy", 32'(busy), 0);

    run_read(14, 4, 0, 0, "wrap");
    fifo_max = 0;
    run_read(0, 16, 1, 0, "bp");
    check("bp_fifo_max_le4", 32'(fifo_max <= 4), 1);

    // Zero-length command: done straight after the start edge, no data.
    base_addr = 4'd5; length = 5'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("len0_done", 32'(done), 1);
    check("len0_valid", 32'(out_valid), 0);
    tick();
    check("len0_done_off", 32'(done), 0);
    check("len0_busy", 32'(busy), 0);
    check("len0_valid2", 32'(out_valid), 0);

    run_read(9, 16, 0, 0, "full");
    run_read(3, 5, 0, 1, "busy_start");

    // Reset while the third word is presented.
    base_addr = 4'd0; length = 5'd8; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    check("mid_third_word", 32'(out_data), 2);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_data", 32'(out_data), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_addr", 32'(read_address), 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("mid_rst_nodone%0d", k), 32'(done), 0);
    end
    rst = 1'b0;
    tick();
    check("post_rst_nodone", 32'(done), 0);
    run_read(0, 2, 0, 0, "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ram_stream_reader.md
# ram_stream_reader

Streaming read engine for the dual-port grid RAM. On a start command it sweeps a contiguous, wrap-around address range, drives the RAM read port, absorbs the RAM's one-cycle registered read latency, and presents the words as a valid/ready stream to the downstream CFD compute pipeline. A small credit-controlled skid FIFO gives full throughput and lossless backpressure.

## Interface
- DATA_WIDTH, default `DATA_WIDTH (def.sv): RAM word width.
- DEPTH, default `DEPTH (def.sv): RAM words; any value ≥2, not necessarily a power of two.
- ADDRESS_WIDTH, default `ADDRESS_WIDTH (def.sv): RAM address width.
- SKID_DEPTH, default 4: output FIFO entries; minimum 4.

- clk  in  1  single clock for the block; rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  command strobe; sampled only in IDLE.
- base_addr  in  ADDRESS_WIDTH  first address; must be < DEPTH.
- length  in  ADDRESS_WIDTH+1  words to read, 0..DEPTH.
- read_address  out  ADDRESS_WIDTH  to RAM read_address.
- ram_data  in  DATA_WIDTH  from RAM data_out.
- out_data  out  DATA_WIDTH  stream data.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- busy  out  1  high from the start edge until the done pulse.
- done  out  1  one-cycle pulse after the last word is accepted.

## Operation
- Reset values: read_address=0, out_valid=0, out_data=0, busy=0, done=0; FSM IDLE; FIFO empty; credits/counters 0.
- FSM: IDLE → (start & length≠0) RUN; IDLE → (start & length=0) DONE; RUN → DRAIN once `length` reads are issued; DRAIN → DONE when the last word is accepted downstream; DONE → IDLE unconditionally (done=1 in DONE only).
- start while not IDLE is ignored; base_addr/length are latched on the accepting edge.
- Issue: in RUN, a read is issued in a cycle when inflight + fifo_count < SKID_DEPTH. inflight counts reads whose data has not yet been written into the FIFO (0..2).
- read_address holds the issued address; on the issuing edge it advances to next = (addr+1 == DEPTH) ? 0 : addr+1. No issue means read_address holds.
- Two-stage valid pipe: stage0 = "read_address was issued last edge"; stage1 = "ram_data is valid now". When stage1=1, ram_data is written into the FIFO on that edge.
- Credit rule guarantees the FIFO never overflows; no data is dropped.
- out_valid = FIFO not empty; out_data = FIFO head (registered storage). Pop on out_valid & out_ready.
- Words are emitted strictly in address order: base, base+1, …, wrapping DEPTH-1 → 0.
- Counters: issued count and accepted count are ADDRESS_WIDTH+1 bits; length=DEPTH is legal and reads every word once.
- rst mid-operation: everything returns to reset values on assertion; no done pulse is produced, and FIFO contents are discarded.

## Timing
- Start edge E0 → read_address=base from E0. ram_data valid after E1. FIFO write at E2. out_valid high after E2 (3-edge latency).
- With out_ready held high: one word per cycle sustained; N words finish with out_valid falling and done rising after edge E(N+2); done is high for one cycle; busy drops with done's falling edge.
- With out_ready low: issuing stops once inflight+fifo_count reaches SKID_DEPTH; out_data/out_valid are stable while stalled.
- Length 0: done pulse one cycle after the start edge; out_valid never asserts.
- Next start is accepted in the cycle after done (in IDLE).

## Structure
- def.sv supplies DATA_WIDTH, DEPTH, ADDRESS_WIDTH; add the FSM state enum (IDLE, RUN, DRAIN, DONE) to the shared package as `reader_state_t`.
- Sub-module: `sync_fifo` (parameters DATA_WIDTH, SKID_DEPTH; push/pop/count/empty/full; async active-high reset). It is reused by later writer/stencil blocks.
- Top level contains the FSM, address/wrap logic, credit counter and valid pipe.

## Test plan
- Pair with RAM preloaded with mem[i]=i, DEPTH=16. Start base=3, length=5, out_ready=1 → stream 3,4,5,6,7 on consecutive cycles; first out_valid 3 edges after start; single done pulse.
- Wrap: base=14, length=4 → 14,15,0,1.
- Backpressure: base=0, length=16, out_ready toggles 1,0,0,1,… randomly → all 0..15 in order exactly once; FIFO count never exceeds 4; out_data stable while stalled.
- length=0 → done one cycle after start; out_valid stays 0. length=16 from base=9 → 9..15,0..8.
- start pulsed again while busy → ignored; the stream is unchanged.
- Assert rst during the 3rd word of a length=8 read → outputs return to reset values immediately, no done; a following start with base=0, length=2 → 0,1 and done.
